// File: rtl/sipo_shift_receiver.sv
// Serial-in/parallel-out receiver for the PISO link: assembles WIDTH-bit words
// and presents them on a held register with a valid/acknowledge handshake.
module sipo_shift_receiver #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     SIn,
  input  logic                     Shift_En,
  input  logic                     Frame_Start,
  input  logic                     Data_Ack,
  input  logic                     Clear_Overrun,
  output logic [WIDTH-1:0]         Data_Out,
  output logic                     Data_Valid,
  output logic                     Overrun,
  output logic [$clog2(WIDTH)-1:0] Bit_Count
);

  localparam int CW = $clog2(WIDTH);

  // RECV: no word pending, FULL: Data_Out holds an unconsumed word
  typedef enum logic {RECV, FULL} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_first;
  logic             w_last;
  logic             w_done;
  logic             w_consume;

  always_comb begin
    if (MSB_FIRST != 0) begin
      w_shifted = {r_shreg[WIDTH-2:0], SIn};
      w_first   = {{(WIDTH-1){1'b0}}, SIn};
    end else begin
      w_shifted = {SIn, r_shreg[WIDTH-1:1]};
      w_first   = {SIn, {(WIDTH-1){1'b0}}};
    end
  end

  // Frame_Start restarts the word, so it can never be the completing bit
  assign w_last    = (r_cnt == CW'(WIDTH-1));
  assign w_done    = Shift_En && !Frame_Start && w_last;
  assign w_consume = r_valid && Data_Ack;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= RECV;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (Frame_Start) begin
        r_shreg <= Shift_En ? w_first : '0;
        r_cnt   <= Shift_En ? CW'(1) : '0;
      end else if (Shift_En) begin
        r_shreg <= w_shifted;
        r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      end

      case (r_state)
        RECV: begin
          if (w_done) begin
            r_data  <= w_shifted;
            r_valid <= 1'b1;
            r_state <= FULL;
          end
        end
        FULL: begin
          if (w_done && w_consume) begin
            r_data <= w_shifted;
          end else if (w_consume) begin
            r_valid <= 1'b0;
            r_state <= RECV;
          end
        end
        default: r_state <= RECV;
      endcase

      // a dropped word outranks a clear in the same cycle
      if (w_done && r_valid && !Data_Ack) begin
        r_overrun <= 1'b1;
      end else if (Clear_Overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign Data_Out   = r_data;
  assign Data_Valid = r_valid;
  assign Overrun    = r_overrun;
  assign Bit_Count  = r_cnt;

endmodule

// File: tb/tb_sipo_shift_receiver.sv
// Directed bench: two receivers (MSB-first and LSB-first) share one stimulus
// stream; each cycle's expected outputs are hand-computed in a vector table.
module tb_sipo_shift_receiver;

  logic       clk = 1'b0;
  logic       rst, sin, se, fs, ack, clr;
  logic [3:0] dout_m, dout_l;
  logic       valid_m, valid_l, ovr_m, ovr_l;
  logic [1:0] cnt_m, cnt_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sipo_shift_receiver #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .Clock(clk), .Reset(rst), .SIn(sin), .Shift_En(se), .Frame_Start(fs),
    .Data_Ack(ack), .Clear_Overrun(clr), .Data_Out(dout_m),
    .Data_Valid(valid_m), .Overrun(ovr_m), .Bit_Count(cnt_m)
  );

  sipo_shift_receiver #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .Clock(clk), .Reset(rst), .SIn(sin), .Shift_En(se), .Frame_Start(fs),
    .Data_Ack(ack), .Clear_Overrun(clr), .Data_Out(dout_l),
    .Data_Valid(valid_l), .Overrun(ovr_l), .Bit_Count(cnt_l)
  );

  typedef struct {
    logic       rst, se, sin, fs, ack, clr;
    logic [3:0] exp_m, exp_l;
    logic       exp_v, exp_o;
    logic [1:0] exp_c;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic d,
                              input logic f, input logic a, input logic c,
                              input logic [3:0] em, input logic [3:0] el,
                              input logic ev, input logic eo, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.se = s; v.sin = d; v.fs = f; v.ack = a; v.clr = c;
    v.exp_m = em; v.exp_l = el; v.exp_v = ev; v.exp_o = eo; v.exp_c = ec;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic d,
                      input logic f, input logic a, input logic c);
    @(negedge clk);
    rst = r; se = s; sin = d; fs = f; ack = a; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] em, input logic [3:0] el,
                         input logic ev, input logic eo, input logic [1:0] ec);
    chk({tag, ".dout_m"},  32'(dout_m),  32'(em));
    chk({tag, ".dout_l"},  32'(dout_l),  32'(el));
    chk({tag, ".valid_m"}, 32'(valid_m), 32'(ev));
    chk({tag, ".valid_l"}, 32'(valid_l), 32'(ev));
    chk({tag, ".ovr_m"},   32'(ovr_m),   32'(eo));
    chk({tag, ".ovr_l"},   32'(ovr_l),   32'(eo));
    chk({tag, ".cnt_m"},   32'(cnt_m),   32'(ec));
    chk({tag, ".cnt_l"},   32'(cnt_l),   32'(ec));
  endtask

  initial begin
    rst = 1'b1; se = 1'b0; sin = 1'b0; fs = 1'b0; ack = 1'b0; clr = 1'b0;

    //  rst se sin fs ack clr   exp_m    exp_l    v  o  cnt
    add(1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // bits 0,1,0,1
    add(0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 3);
    add(0, 1, 1, 0, 0, 0, 4'b0101, 4'b1010, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0101, 4'b1010, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0101, 4'b1010, 0, 0, 0);
    // bits 1,1, gap of 3 with SIn toggling, then 0,0
    add(0, 1, 1, 0, 0, 0, 4'b0101, 4'b1010, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 4'b0101, 4'b1010, 0, 0, 2);
    add(0, 0, 1, 0, 0, 0, 4'b0101, 4'b1010, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 4'b0101, 4'b1010, 0, 0, 2);
    add(0, 0, 1, 0, 0, 0, 4'b0101, 4'b1010, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 4'b0101, 4'b1010, 0, 0, 3);
    add(0, 1, 0, 0, 0, 0, 4'b1100, 4'b0011, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b1100, 4'b0011, 0, 0, 0);
    // bits 1,1,1, Frame_Start with SIn=0, then 1,1,0
    add(0, 1, 1, 0, 0, 0, 4'b1100, 4'b0011, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 4'b1100, 4'b0011, 0, 0, 2);
    add(0, 1, 1, 0, 0, 0, 4'b1100, 4'b0011, 0, 0, 3);
    add(0, 1, 0, 1, 0, 0, 4'b1100, 4'b0011, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 4'b1100, 4'b0011, 0, 0, 2);
    add(0, 1, 1, 0, 0, 0, 4'b1100, 4'b0011, 0, 0, 3);
    add(0, 1, 0, 0, 0, 0, 4'b0110, 4'b0110, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0110, 4'b0110, 0, 0, 0);
    // Frame_Start without Shift_En zeroes the count
    add(0, 1, 1, 0, 0, 0, 4'b0110, 4'b0110, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 4'b0110, 4'b0110, 0, 0, 0);
    // 0101 left pending, 0011 completes un-acked -> overrun
    add(0, 1, 0, 0, 0, 0, 4'b0110, 4'b0110, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 4'b0110, 4'b0110, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 4'b0110, 4'b0110, 0, 0, 3);
    add(0, 1, 1, 0, 0, 0, 4'b0101, 4'b1010, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 4'b0101, 4'b1010, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 4'b0101, 4'b1010, 1, 0, 2);
    add(0, 1, 1, 0, 0, 0, 4'b0101, 4'b1010, 1, 0, 3);
    add(0, 1, 1, 0, 0, 0, 4'b0101, 4'b1010, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0101, 4'b1010, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0101, 4'b1010, 0, 0, 0);
    // 1001 pending, 0110 completes on the acking edge
    add(0, 1, 1, 0, 0, 0, 4'b0101, 4'b1010, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 4'b0101, 4'b1010, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 4'b0101, 4'b1010, 0, 0, 3);
    add(0, 1, 1, 0, 0, 0, 4'b1001, 4'b1001, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 4'b1001, 4'b1001, 1, 0, 1);
    add(0, 1, 1, 0, 0, 0, 4'b1001, 4'b1001, 1, 0, 2);
    add(0, 1, 1, 0, 0, 0, 4'b1001, 4'b1001, 1, 0, 3);
    add(0, 1, 0, 0, 1, 0, 4'b0110, 4'b0110, 1, 0, 0);
    // overrun set and Clear_Overrun on the same edge: set wins
    add(0, 1, 1, 0, 0, 0, 4'b0110, 4'b0110, 1, 0, 1);
    add(0, 1, 1, 0, 0, 0, 4'b0110, 4'b0110, 1, 0, 2);
    add(0, 1, 1, 0, 0, 0, 4'b0110, 4'b0110, 1, 0, 3);
    add(0, 1, 1, 0, 0, 1, 4'b0110, 4'b0110, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 4'b0110, 4'b0110, 0, 0, 0);
    // word pending + overrun + partial word, then reset
    add(0, 1, 1, 0, 0, 0, 4'b0110, 4'b0110, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 4'b0110, 4'b0110, 0, 0, 2);
    add(0, 1, 1, 0, 0, 0, 4'b0110, 4'b0110, 0, 0, 3);
    add(0, 1, 0, 0, 0, 0, 4'b1010, 4'b0101, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 4'b1010, 4'b0101, 1, 0, 1);
    add(0, 1, 1, 0, 0, 0, 4'b1010, 4'b0101, 1, 0, 2);
    add(0, 1, 0, 0, 0, 0, 4'b1010, 4'b0101, 1, 0, 3);
    add(0, 1, 0, 0, 0, 0, 4'b1010, 4'b0101, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 4'b1010, 4'b0101, 1, 1, 1);
    add(1, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].se, vecs[i].sin, vecs[i].fs, vecs[i].ack, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_m, vecs[i].exp_l,
              vecs[i].exp_v, vecs[i].exp_o, vecs[i].exp_c);
    end

    // Frame_Start landing where bit 3 would have been must not complete a word
    step(1, 0, 0, 0, 0, 0);
    chk_all("fs_rst", 4'b0000, 4'b0000, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    chk_all("fs_at_bit3", 4'b0000, 4'b0000, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk_all("fs_word", 4'b1001, 4'b1001, 1, 0, 0);

    // held word stays stable while un-acked and idle
    for (int k = 0; k < 4; k++) begin
      step(0, 0, k[0], 0, 0, 0);
      chk_all($sformatf("hold%0d", k), 4'b1001, 4'b1001, 1, 0, 0);
    end
    step(0, 0, 0, 0, 1, 0);
    chk_all("hold_ack", 4'b1001, 4'b1001, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_shift_receiver.md
Name: sipo_shift_receiver

Overview:
- Serial-in/parallel-out deserializer: the receive end of the team's PISO serial link.
- Samples one serial bit per qualified clock and assembles WIDTH-bit words.
- Presents each completed word on a held output register with a valid/acknowledge handshake.
- Flags overrun when a word completes before the previous one is consumed; sits between the serial line and parallel consumer logic.

Parameters:
- WIDTH, 4, word length in bits (>= 2).
- MSB_FIRST, 1, 1 = first received bit lands in Data_Out[WIDTH-1]; 0 = first bit lands in Data_Out[0].

Ports:
- Clock, input, 1, single rising-edge clock.
- Reset, input, 1, synchronous, active-high reset.
- SIn, input, 1, serial data bit.
- Shift_En, input, 1, qualifies SIn; a bit is sampled only on cycles with Shift_En=1.
- Frame_Start, input, 1, resynchronises the bit counter to bit 0.
- Data_Ack, input, 1, consumer accepts Data_Out.
- Data_Out, output, WIDTH, last completed word (held).
- Data_Valid, output, 1, Data_Out holds an unconsumed word.
- Overrun, output, 1, sticky: a completed word was dropped.
- Clear_Overrun, input, 1, clears Overrun.
- Bit_Count, output, clog2(WIDTH), bits collected in the current partial word.

Behaviour:
- Reset (synchronous, checked every edge, overrides all other inputs):
  - shift register, Data_Out, Bit_Count: 0.
  - Data_Valid, Overrun: 0.
  - Any partial word is discarded.
- Shift, MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], SIn}.
- Shift, MSB_FIRST=0: shreg <= {SIn, shreg[WIDTH-1:1]}.
- Only on Shift_En=1 cycles. Shift_En=0: shreg and Bit_Count hold, SIn ignored.
- Bit counter: increments per sampled bit and wraps WIDTH-1 -> 0 on the completing bit.
- Frame_Start=1 with Shift_En=1: discard the partial word, take SIn as bit 0 (shreg becomes the new bit only), Bit_Count <= 1.
- Frame_Start=1 with Shift_En=0: discard the partial word, Bit_Count <= 0.
- Completion: the sampled bit is bit WIDTH-1.
  - Assembled word (including that bit) is written to Data_Out on the same edge.
  - Data_Valid=1 from the following cycle, i.e. latency 1 clock from the last bit's sampling edge to visible word.
- Handshake:
  - Word is consumed on an edge where Data_Valid=1 and Data_Ack=1.
  - Data_Valid stays 1 and Data_Out stays stable until consumed.
  - Data_Ack while Data_Valid=0 is ignored.
- Simultaneous completion + consume (Data_Valid=1, Data_Ack=1): new word loads, Data_Valid stays 1, no overrun.
- Completion while Data_Valid=1 and Data_Ack=0:
  - New word dropped; Data_Out keeps the old word.
  - Overrun <= 1; Bit_Count still wraps to 0.
- Completion while Data_Valid=0: load, Data_Valid <= 1.
- Overrun:
  - Sticky until Reset or Clear_Overrun=1.
  - Set condition and Clear_Overrun in the same cycle: set wins, Overrun=1.
- Reset mid-frame or with Data_Valid=1: everything cleared per reset values; no word emitted.
- No combinational path from inputs to outputs; all outputs are registered.
- Internal state: RECV (collecting) / FULL (Data_Valid=1). Reception continues in both states; FULL only governs load-vs-drop.
  - RECV -> FULL on completion.
  - FULL -> RECV on consume without simultaneous completion.

Test Plan (WIDTH=4):
- Reset, then MSB_FIRST=1, Shift_En=1 for 4 cycles, SIn=0,1,0,1 -> Data_Out=4'b0101, Data_Valid=1 one cycle after the 4th bit, Bit_Count=0.
- MSB_FIRST=0, same bits 0,1,0,1 -> Data_Out=4'b1010.
- Bits 1,1 with Shift_En, then Shift_En=0 for 3 cycles, then bits 0,0 -> Data_Out=4'b1100; Bit_Count holds at 2 during the gap.
- Bits 1,1,1, then Frame_Start=1 with Shift_En=1 and SIn=0, then bits 1,1,0 -> Data_Out=4'b0110; partial 111 discarded.
- Word 0101 left un-acked, second word 0011 completes with Data_Ack=0 -> Data_Out stays 0101, Overrun=1. Data_Ack -> Data_Valid=0. Clear_Overrun -> Overrun=0.
- Word A=1001 pending; second word 0110 completes on the same edge as Data_Ack=1 -> Data_Out=0110, Data_Valid stays 1, Overrun=0. Separately, Reset asserted after 2 bits -> all outputs 0 the next cycle.
